// File: rtl/local_memory_dp.sv
// local_memory_dp: parametrised true-dual-port local store.
// Port A serves the coprocessor datapath and port B the host/config side.
// Both ports have byte enables, a clock enable and a 1- or 2-cycle read
// pipeline. Same-address conflicts are resolved deterministically and
// counted. Out-of-range accesses are flagged.

// Per-port read pipeline. Stage 0 captures the read-first RAM data at the
// accepting edge. Every stage advances only while ce_i is high. The last
// stage's valid bit is a one-cycle pulse.
module lmdp_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_i,
  input  logic          rd_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] data_o,
  output logic          vld_o
);
  logic [LAT-1:0]         vld_pipe_q;
  logic [LAT-1:0][DW-1:0] dat_pipe_q;
  logic [LAT-1:0]         vld_d;
  logic [LAT-1:0][DW-1:0] dat_d;

  // Stage inputs: stage 0 takes the RAM read, later stages take the previous stage
  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = rd_i;
    dat_d[0] = rdata_i;
    for (int s = 1; s < LAT; s++) begin
      vld_d[s] = vld_pipe_q[s-1];
      dat_d[s] = dat_pipe_q[s-1];
    end
  end

  // Advance on ce. Mid stages hold while stalled. The output valid drops so it never repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      for (int s = 0; s < LAT; s++) begin
        if (ce_i) begin
          vld_pipe_q[s] <= vld_d[s];
          if (vld_d[s]) dat_pipe_q[s] <= dat_d[s];
        end else if (s == LAT-1) begin
          vld_pipe_q[s] <= 1'b0;
        end
      end
    end
  end

  assign vld_o  = vld_pipe_q[LAT-1];
  assign data_o = dat_pipe_q[LAT-1];
endmodule

module local_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_MEM     = 256,
  parameter int SIZE_ADDR    = 8,
  parameter int READ_LATENCY = 1,
  parameter int WR_PRIORITY  = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    ce_a,
  input  logic                    rden_a,
  input  logic                    wren_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [SIZE_ADDR-1:0]    address_a,
  input  logic [DATA_WIDTH-1:0]   data_in_a,
  output logic [DATA_WIDTH-1:0]   data_out_a,
  output logic                    rdvalid_a,
  input  logic                    ce_b,
  input  logic                    rden_b,
  input  logic                    wren_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [SIZE_ADDR-1:0]    address_b,
  input  logic [DATA_WIDTH-1:0]   data_in_b,
  output logic [DATA_WIDTH-1:0]   data_out_b,
  output logic                    rdvalid_b,
  input  logic                    clr_stat,
  output logic                    collision,
  output logic [15:0]             coll_cnt,
  output logic                    addr_err
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int WIN  = (WR_PRIORITY != 0) ? 1 : 0;
  localparam int LOSE = 1 - WIN;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $fatal(1, "local_memory_dp: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "local_memory_dp: READ_LATENCY must be 1 or 2");
  end
  if (SIZE_MEM < 1 || SIZE_MEM > (2 ** SIZE_ADDR)) begin : g_bad_size
    $fatal(1, "local_memory_dp: SIZE_MEM must be in 1 .. 2**SIZE_ADDR");
  end

  logic [DATA_WIDTH-1:0] ram [SIZE_MEM];

  // Index 0 is port A and index 1 is port B.
  logic [1:0]                 ce, rd, wr, acc_rd, acc_wr, inr, rvld;
  logic [1:0][SIZE_ADDR-1:0]  addr;
  logic [1:0][NB-1:0]         be, wen;
  logic [1:0][DATA_WIDTH-1:0] din, rdata, dout;
  logic                       coll_ev, oor_ev;
  logic                       collision_q, addr_err_q;
  logic [15:0]                coll_cnt_q;

  assign ce   = {ce_b, ce_a};
  assign rd   = {rden_b, rden_a};
  assign wr   = {wren_b, wren_a};
  assign be   = {be_b, be_a};
  assign addr = {address_b, address_a};
  assign din  = {data_in_b, data_in_a};

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign acc_rd[p] = ce[p] & rd[p];
    assign acc_wr[p] = ce[p] & wr[p];
    assign inr[p]    = 32'(addr[p]) < SIZE_MEM;
    assign wen[p]    = be[p] & {NB{acc_wr[p] & inr[p]}};
    // Read-first: the pipeline captures pre-write contents. Out of range reads as zero.
    assign rdata[p]  = inr[p] ? ram[addr[p]] : '0;

    lmdp_rd_pipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_rd_pipe (
      .clk     (aclk),
      .rst_n   (aresetn),
      .ce_i    (ce[p]),
      .rd_i    (acc_rd[p]),
      .rdata_i (rdata[p]),
      .data_o  (dout[p]),
      .vld_o   (rvld[p])
    );
  end

  assign coll_ev = (acc_rd[0] | acc_wr[0]) & (acc_rd[1] | acc_wr[1]) & inr[0] & inr[1]
                 & (addr[0] == addr[1]) & (acc_wr[0] | acc_wr[1]);
  assign oor_ev  = ((acc_rd[0] | acc_wr[0]) & ~inr[0]) | ((acc_rd[1] | acc_wr[1]) & ~inr[1]);

  // Byte writes. The losing port is written first so the winner's byte lands on overlaps.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NB; i++) begin
      if (wen[LOSE][i]) ram[addr[LOSE]][8*i +: 8] <= din[LOSE][8*i +: 8];
      if (wen[WIN][i])  ram[addr[WIN]][8*i +: 8]  <= din[WIN][8*i +: 8];
    end
  end

  // Collision pulse, saturating counter and sticky range error. clr_stat beats any same-cycle event.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      collision_q <= coll_ev;
      if (clr_stat) begin
        coll_cnt_q <= '0;
        addr_err_q <= 1'b0;
      end else begin
        if (coll_ev && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
        if (oor_ev) addr_err_q <= 1'b1;
      end
    end
  end

  assign data_out_a = dout[0];
  assign rdvalid_a  = rvld[0];
  assign data_out_b = dout[1];
  assign rdvalid_b  = rvld[1];
  assign collision  = collision_q;
  assign coll_cnt   = coll_cnt_q;
  assign addr_err   = addr_err_q;
endmodule

// File: tb/tb_local_memory_dp.sv
// Bench for local_memory_dp. Two instances share one stimulus stream.
// u_dut0 uses the default parameters.
// u_dut1 uses SIZE_MEM=200, READ_LATENCY=2 and WR_PRIORITY=1.
module tb_local_memory_dp;
  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        ce_a, rden_a, wren_a, ce_b, rden_b, wren_b, clr_stat;
  logic [3:0]  be_a, be_b;
  logic [7:0]  address_a, address_b;
  logic [31:0] data_in_a, data_in_b;
  logic [31:0] dout_a [2];
  logic [31:0] dout_b [2];
  logic        rv_a [2];
  logic        rv_b [2];
  logic        coll [2];
  logic        aerr [2];
  logic [15:0] ccnt [2];

  always #5 aclk = ~aclk;

  local_memory_dp u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .ce_a(ce_a), .rden_a(rden_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
    .data_in_a(data_in_a), .data_out_a(dout_a[0]), .rdvalid_a(rv_a[0]),
    .ce_b(ce_b), .rden_b(rden_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
    .data_in_b(data_in_b), .data_out_b(dout_b[0]), .rdvalid_b(rv_b[0]),
    .clr_stat(clr_stat), .collision(coll[0]), .coll_cnt(ccnt[0]), .addr_err(aerr[0])
  );

  local_memory_dp #(.SIZE_MEM(200), .READ_LATENCY(2), .WR_PRIORITY(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .ce_a(ce_a), .rden_a(rden_a), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
    .data_in_a(data_in_a), .data_out_a(dout_a[1]), .rdvalid_a(rv_a[1]),
    .ce_b(ce_b), .rden_b(rden_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
    .data_in_b(data_in_b), .data_out_b(dout_b[1]), .rdvalid_b(rv_b[1]),
    .clr_stat(clr_stat), .collision(coll[1]), .coll_cnt(ccnt[1]), .addr_err(aerr[1])
  );

  // Reference model: word array per instance, read results in order per port, stats.
  logic [31:0] mem [2][256];
  logic [31:0] sb [4][$];
  logic [31:0] last [4];
  bit          m_coll [2];
  bit          m_err [2];
  int          m_cnt [2];
  int          n_cmp = 0, n_bad = 0;

  function automatic int szof(int k);
    return (k != 0) ? 200 : 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_coll[k] = 1'b0; m_err[k] = 1'b0; m_cnt[k] = 0;
    end
    for (int q = 0; q < 4; q++) begin
      sb[q].delete(); last[q] = 32'h0;
    end
  endtask

  // Apply the current inputs to the model as if at the next rising edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit ina, inb, aa, ab, ev, wa, wb;
      ina = int'(address_a) < szof(k);
      inb = int'(address_b) < szof(k);
      aa  = ce_a && (rden_a || wren_a);
      ab  = ce_b && (rden_b || wren_b);
      if (ce_a && rden_a) sb[2*k].push_back(ina ? mem[k][address_a] : 32'h0);
      if (ce_b && rden_b) sb[2*k+1].push_back(inb ? mem[k][address_b] : 32'h0);
      for (int i = 0; i < 4; i++) begin
        wa = ce_a && wren_a && ina && be_a[i];
        wb = ce_b && wren_b && inb && be_b[i];
        if (wa && wb && address_a == address_b)
          mem[k][address_a][8*i +: 8] = (k == 1) ? data_in_b[8*i +: 8] : data_in_a[8*i +: 8];
        else begin
          if (wa) mem[k][address_a][8*i +: 8] = data_in_a[8*i +: 8];
          if (wb) mem[k][address_b][8*i +: 8] = data_in_b[8*i +: 8];
        end
      end
      ev = aa && ab && ina && inb && (address_a == address_b) && (wren_a || wren_b);
      m_coll[k] = ev;
      if (clr_stat) begin
        m_cnt[k] = 0; m_err[k] = 1'b0;
      end else begin
        if (ev && m_cnt[k] < 65535) m_cnt[k]++;
        if ((aa && !ina) || (ab && !inb)) m_err[k] = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    ce_a = 1'b1; rden_a = 1'b0; wren_a = 1'b0; be_a = 4'h0; address_a = 8'h0; data_in_a = 32'h0;
    ce_b = 1'b1; rden_b = 1'b0; wren_b = 1'b0; be_b = 4'h0; address_b = 8'h0; data_in_b = 32'h0;
    clr_stat = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dout_a[k] !== 32'h0) begin n_bad++; $display("FAIL reset_dout_a%0d got %h exp 0", k, dout_a[k]); end
      n_cmp++; if (dout_b[k] !== 32'h0) begin n_bad++; $display("FAIL reset_dout_b%0d got %h exp 0", k, dout_b[k]); end
      n_cmp++; if (rv_a[k] !== 1'b0) begin n_bad++; $display("FAIL reset_rv_a%0d got %b exp 0", k, rv_a[k]); end
      n_cmp++; if (rv_b[k] !== 1'b0) begin n_bad++; $display("FAIL reset_rv_b%0d got %b exp 0", k, rv_b[k]); end
      n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL reset_coll%0d got %b exp 0", k, coll[k]); end
      n_cmp++; if (ccnt[k] !== 16'h0) begin n_bad++; $display("FAIL reset_ccnt%0d got %h exp 0", k, ccnt[k]); end
      n_cmp++; if (aerr[k] !== 1'b0) begin n_bad++; $display("FAIL reset_aerr%0d got %b exp 0", k, aerr[k]); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    wren_a = 1'b1; address_a = 8'h10; data_in_a = 32'hDEADBEEF; be_a = 4'hF; cyc();
    idle(); cyc();
    rden_b = 1'b1; address_b = 8'h10; cyc();
    idle();
    n_cmp++; if (rv_b[0] !== 1'b1) begin n_bad++; $display("FAIL basic_rv_b0_l1 got %b exp 1", rv_b[0]); end
    n_cmp++; if (dout_b[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_dout_b0 got %h exp deadbeef", dout_b[0]); end
    n_cmp++; if (rv_b[1] !== 1'b0) begin n_bad++; $display("FAIL basic_rv_b1_early got %b exp 0", rv_b[1]); end
    cyc();
    n_cmp++; if (rv_b[0] !== 1'b0) begin n_bad++; $display("FAIL basic_rv_b0_pulse got %b exp 0", rv_b[0]); end
    n_cmp++; if (dout_b[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_dout_b0_hold got %h exp deadbeef", dout_b[0]); end
    n_cmp++; if (rv_b[1] !== 1'b1) begin n_bad++; $display("FAIL basic_rv_b1_l2 got %b exp 1", rv_b[1]); end
    n_cmp++; if (dout_b[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_dout_b1 got %h exp deadbeef", dout_b[1]); end
    n_cmp++; if (ccnt[0] !== 16'h0) begin n_bad++; $display("FAIL basic_ccnt0 got %h exp 0", ccnt[0]); end
  endtask

  task automatic test_byte_en();
    idle(); wren_a = 1'b1; address_a = 8'd5; data_in_a = 32'h11223344; be_a = 4'hF; cyc();
    data_in_a = 32'hAABBCCDD; be_a = 4'b0101; cyc();
    data_in_a = 32'hFFFFFFFF; be_a = 4'b0000; cyc();
    idle(); rden_a = 1'b1; address_a = 8'd5; cyc();
    idle();
    n_cmp++; if (dout_a[0] !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_dout_a0 got %h exp 11bb33dd", dout_a[0]); end
    cyc();
    n_cmp++; if (dout_a[1] !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_dout_a1 got %h exp 11bb33dd", dout_a[1]); end
  endtask

  task automatic test_ww_collision();
    do_reset();
    wren_a = 1'b1; address_a = 8'd7; data_in_a = 32'hAAAAAAAA; be_a = 4'hF;
    wren_b = 1'b1; address_b = 8'd7; data_in_b = 32'hBBBBBBBB; be_b = 4'hC;
    cyc();
    idle();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (coll[k] !== 1'b1) begin n_bad++; $display("FAIL ww_coll%0d got %b exp 1", k, coll[k]); end
      n_cmp++; if (ccnt[k] !== 16'd1) begin n_bad++; $display("FAIL ww_ccnt%0d got %h exp 1", k, ccnt[k]); end
    end
    rden_a = 1'b1; address_a = 8'd7; cyc();
    idle();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL ww_coll_pulse%0d got %b exp 0", k, coll[k]); end
    end
    n_cmp++; if (dout_a[0] !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL ww_prio0 got %h exp aaaaaaaa", dout_a[0]); end
    cyc();
    n_cmp++; if (dout_a[1] !== 32'hBBBBAAAA) begin n_bad++; $display("FAIL ww_prio1 got %h exp bbbbaaaa", dout_a[1]); end
  endtask

  task automatic test_rw_stall();
    do_reset();
    wren_a = 1'b1; address_a = 8'd3; data_in_a = 32'd1; be_a = 4'hF; cyc();
    idle(); rden_a = 1'b1; address_a = 8'd3;
    wren_b = 1'b1; address_b = 8'd3; data_in_b = 32'd2; be_b = 4'hF; cyc();
    idle(); ce_a = 1'b0;
    n_cmp++; if (coll[1] !== 1'b1) begin n_bad++; $display("FAIL rw_coll1 got %b exp 1", coll[1]); end
    n_cmp++; if (rv_a[0] !== 1'b1 || dout_a[0] !== 32'd1) begin n_bad++; $display("FAIL rw_old_a0 got %b/%h exp 1/1", rv_a[0], dout_a[0]); end
    n_cmp++; if (rv_a[1] !== 1'b0) begin n_bad++; $display("FAIL rw_stall_rv1_c0 got %b exp 0", rv_a[1]); end
    cyc();
    n_cmp++; if (rv_a[1] !== 1'b0) begin n_bad++; $display("FAIL rw_stall_rv1_c1 got %b exp 0", rv_a[1]); end
    cyc();
    n_cmp++; if (rv_a[1] !== 1'b0) begin n_bad++; $display("FAIL rw_stall_rv1_c2 got %b exp 0", rv_a[1]); end
    ce_a = 1'b1; cyc();
    n_cmp++; if (rv_a[1] !== 1'b1) begin n_bad++; $display("FAIL rw_stall_rv1_release got %b exp 1", rv_a[1]); end
    n_cmp++; if (dout_a[1] !== 32'd1) begin n_bad++; $display("FAIL rw_stall_old1 got %h exp 1", dout_a[1]); end
    rden_a = 1'b1; address_a = 8'd3; cyc();
    idle();
    n_cmp++; if (dout_a[0] !== 32'd2) begin n_bad++; $display("FAIL rw_new_a0 got %h exp 2", dout_a[0]); end
    cyc();
    n_cmp++; if (rv_a[1] !== 1'b1 || dout_a[1] !== 32'd2) begin n_bad++; $display("FAIL rw_new_a1 got %b/%h exp 1/2", rv_a[1], dout_a[1]); end
  endtask

  task automatic test_oor();
    do_reset();
    wren_a = 1'b1; address_a = 8'd50; data_in_a = 32'h12345678; be_a = 4'hF; cyc();
    idle(); rden_b = 1'b1; address_b = 8'd50; cyc();
    idle(); cyc();
    wren_a = 1'b1; address_a = 8'd250; data_in_a = 32'hCAFEF00D; be_a = 4'hF;
    rden_b = 1'b1; address_b = 8'd250; cyc();
    idle();
    n_cmp++; if (aerr[1] !== 1'b1) begin n_bad++; $display("FAIL oor_aerr1 got %b exp 1", aerr[1]); end
    n_cmp++; if (coll[1] !== 1'b0) begin n_bad++; $display("FAIL oor_nocoll1 got %b exp 0", coll[1]); end
    n_cmp++; if (aerr[0] !== 1'b0) begin n_bad++; $display("FAIL oor_aerr0 got %b exp 0", aerr[0]); end
    n_cmp++; if (coll[0] !== 1'b1) begin n_bad++; $display("FAIL oor_coll0 got %b exp 1", coll[0]); end
    cyc();
    n_cmp++; if (rv_b[1] !== 1'b1 || dout_b[1] !== 32'h0) begin n_bad++; $display("FAIL oor_read1 got %b/%h exp 1/0", rv_b[1], dout_b[1]); end
    n_cmp++; if (ccnt[1] !== 16'h0) begin n_bad++; $display("FAIL oor_ccnt1 got %h exp 0", ccnt[1]); end
    cyc(); cyc();
    n_cmp++; if (aerr[1] !== 1'b1) begin n_bad++; $display("FAIL oor_sticky1 got %b exp 1", aerr[1]); end
    rden_a = 1'b1; address_a = 8'd50; cyc();
    idle(); cyc();
    n_cmp++; if (dout_a[1] !== 32'h12345678) begin n_bad++; $display("FAIL oor_unchanged1 got %h exp 12345678", dout_a[1]); end
    clr_stat = 1'b1; rden_b = 1'b1; address_b = 8'd201; cyc();
    idle();
    n_cmp++; if (aerr[1] !== 1'b0) begin n_bad++; $display("FAIL oor_clr_wins1 got %b exp 0", aerr[1]); end
    cyc();
    n_cmp++; if (aerr[1] !== 1'b0) begin n_bad++; $display("FAIL oor_cleared1 got %b exp 0", aerr[1]); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    wren_a = 1'b1; address_a = 8'd3; data_in_a = 32'h0BADF00D; be_a = 4'hF; cyc();
    idle(); rden_a = 1'b1; address_a = 8'd3; cyc();
    idle(); cyc();
    rden_a = 1'b1; address_a = 8'd3; wren_b = 1'b1; address_b = 8'd3; data_in_b = 32'h1; be_b = 4'hF; cyc();
    idle();
    n_cmp++; if (dout_a[1] !== 32'h0BADF00D) begin n_bad++; $display("FAIL rmid_pre_dout1 got %h exp 0badf00d", dout_a[1]); end
    n_cmp++; if (ccnt[0] !== 16'd1) begin n_bad++; $display("FAIL rmid_pre_ccnt0 got %h exp 1", ccnt[0]); end
    #2 aresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dout_a[k] !== 32'h0) begin n_bad++; $display("FAIL rmid_dout%0d got %h exp 0", k, dout_a[k]); end
      n_cmp++; if (rv_a[k] !== 1'b0) begin n_bad++; $display("FAIL rmid_rv%0d got %b exp 0", k, rv_a[k]); end
      n_cmp++; if (coll[k] !== 1'b0) begin n_bad++; $display("FAIL rmid_coll%0d got %b exp 0", k, coll[k]); end
      n_cmp++; if (ccnt[k] !== 16'h0) begin n_bad++; $display("FAIL rmid_ccnt%0d got %h exp 0", k, ccnt[k]); end
    end
    model_reset();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_cmp++; if (rv_a[1] !== 1'b0) begin n_bad++; $display("FAIL rmid_norv1_c%0d got %b exp 0", c, rv_a[1]); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    wren_a = 1'b1; address_a = 8'd9; data_in_a = $urandom; be_a = 4'hF;
    wren_b = 1'b1; address_b = 8'd9; data_in_b = $urandom; be_b = 4'hF;
    repeat (65535) cyc();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ccnt[k] !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach%0d got %h exp ffff", k, ccnt[k]); end
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ccnt[k] !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold%0d got %h exp ffff", k, ccnt[k]); end
    end
    clr_stat = 1'b1; cyc();
    idle();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ccnt[k] !== 16'h0) begin n_bad++; $display("FAIL sat_clr_wins%0d got %h exp 0", k, ccnt[k]); end
      n_cmp++; if (coll[k] !== 1'b1) begin n_bad++; $display("FAIL sat_coll%0d got %b exp 1", k, coll[k]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  pool [14];
    logic        v;
    logic [31:0] d, e;
    int          idx;
    do_reset();
    for (int i = 0; i < 8; i++) pool[i] = 8'(i);
    for (int i = 0; i < 6; i++) pool[8+i] = 8'(198 + i);
    for (int i = 0; i < 14; i++) begin
      idle(); wren_a = 1'b1; address_a = pool[i]; data_in_a = $urandom; be_a = 4'hF; cyc();
    end
    idle(); clr_stat = 1'b1; cyc();
    idle(); cyc();
    for (int n = 0; n < 604; n++) begin
      idle();
      if (n < 600) begin
        ce_a = ($urandom_range(0, 4) != 0); rden_a = 1'($urandom); wren_a = 1'($urandom);
        ce_b = ($urandom_range(0, 4) != 0); rden_b = 1'($urandom); wren_b = 1'($urandom);
        be_a = 4'($urandom); be_b = 4'($urandom);
        address_a = pool[$urandom_range(0, 13)]; address_b = pool[$urandom_range(0, 13)];
        data_in_a = $urandom; data_in_b = $urandom;
        clr_stat = ($urandom_range(0, 19) == 0);
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (coll[k] !== m_coll[k]) begin n_bad++; $display("FAIL rnd_coll%0d n=%0d got %b exp %b", k, n, coll[k], m_coll[k]); end
        n_cmp++; if (ccnt[k] !== 16'(m_cnt[k])) begin n_bad++; $display("FAIL rnd_ccnt%0d n=%0d got %h exp %h", k, n, ccnt[k], 16'(m_cnt[k])); end
        n_cmp++; if (aerr[k] !== m_err[k]) begin n_bad++; $display("FAIL rnd_aerr%0d n=%0d got %b exp %b", k, n, aerr[k], m_err[k]); end
        for (int p = 0; p < 2; p++) begin
          idx = 2*k + p;
          v = (p != 0) ? rv_b[k] : rv_a[k];
          d = (p != 0) ? dout_b[k] : dout_a[k];
          n_cmp++;
          if (v === 1'b1) begin
            if (sb[idx].size() == 0) begin
              n_bad++; $display("FAIL rnd_spurious_rv dut%0d port%0d n=%0d got 1 exp 0", k, p, n);
            end else begin
              e = sb[idx].pop_front();
              last[idx] = e;
              if (d !== e) begin n_bad++; $display("FAIL rnd_rdata dut%0d port%0d n=%0d got %h exp %h", k, p, n, d, e); end
            end
          end else if (d !== last[idx]) begin
            n_bad++; $display("FAIL rnd_hold dut%0d port%0d n=%0d got %h exp %h", k, p, n, d, last[idx]);
          end
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      n_cmp++; if (sb[q].size() != 0) begin n_bad++; $display("FAIL rnd_missing_rv q%0d got %0d pending exp 0", q, sb[q].size()); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_byte_en();
    test_ww_collision();
    test_rw_stall();
    test_oor();
    test_reset_mid_read();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/local_memory_dp.md
Name: local_memory_dp

Overview:
- Parametrised true-dual-port local memory; successor to the fixed 32-bit/256-word local store used by the coprocessor memory map.
- Adds: configurable data width and depth, per-byte write enables, per-port clock enables, selectable 1- or 2-cycle read latency with read-valid strobes, deterministic same-address collision resolution, out-of-range detection, and a saturating collision counter.
- Sits between the coprocessor datapath (port A) and the host/config interface (port B).

Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- SIZE_MEM, 256: number of words; 1 .. 2**SIZE_ADDR.
- SIZE_ADDR, 8: address width.
- READ_LATENCY, 1: 1 or 2 clock cycles from an accepted read to data_out/rdvalid.
- WR_PRIORITY, 0: on a same-address, same-byte write by both ports, 0 means A wins and 1 means B wins.

Ports:
- aclk  in  1  clock; all logic on posedge.
- aresetn  in  1  asynchronous active-low reset.
- ce_a  in  1  port A clock enable; gates A accepts and A pipeline advance.
- rden_a  in  1  port A read request.
- wren_a  in  1  port A write request.
- be_a  in  DATA_WIDTH/8  port A byte enables.
- address_a  in  SIZE_ADDR  port A word address.
- data_in_a  in  DATA_WIDTH  port A write data.
- data_out_a  out  DATA_WIDTH  port A read data (registered).
- rdvalid_a  out  1  port A read-data valid, one-cycle pulse.
- ce_b, rden_b, wren_b, be_b, address_b, data_in_b, data_out_b, rdvalid_b: same as port A, for port B.
- clr_stat  in  1  synchronous clear of coll_cnt and addr_err.
- collision  out  1  registered pulse; same-address conflict in the previous cycle.
- coll_cnt  out  16  saturating count of collision events.
- addr_err  out  1  sticky; set when any accepted access is out of range.

Behaviour:
- Reset (aresetn=0, async): data_out_a/b=0, rdvalid_a/b=0, read pipelines cleared, collision=0, coll_cnt=0, addr_err=0. RAM contents are not reset. A read in flight at reset is discarded; no rdvalid is ever issued for it.
- Accept: port X access is accepted on a posedge with ce_X=1 and rden_X or wren_X. Any request with ce_X=0 is ignored.
- Write: for each byte i with be_X[i]=1, ram[addr][8i+7:8i] <= data_in_X byte i. be_X=0 means no change.
- Read:
  - The RAM is read-first: a read returns the contents before any same-cycle write from either port, including the same port.
  - READ_LATENCY=1: data_out_X and rdvalid_X are updated at the accepting edge and visible the next cycle.
  - READ_LATENCY=2: one extra register stage.
  - Pipeline stages advance only when ce_X=1. With ce_X=0, data_out_X and the stage contents hold and rdvalid_X=0.
  - rdvalid_X=1 for exactly one cycle per accepted read. data_out_X holds its last value until the next valid read.
- Simultaneous read+write on the same port: both are performed; the read returns the old data.
- Collision: both ports accepted on the same in-range address with at least one write.
  - Write/write: bytes enabled on only one port are written by that port. Overlapping bytes take the WR_PRIORITY winner's data.
  - Read/write: the reader gets the old data.
  - collision pulses 1 on the following cycle. coll_cnt increments by 1 per event and saturates at 0xFFFF.
- Out of range (address >= SIZE_MEM): the write is suppressed; the read returns 0 with a normal rdvalid; addr_err is set. Such an access never counts as a collision.
- clr_stat=1: coll_cnt and addr_err are cleared on the next edge. If an event occurs in the same cycle, clr wins and the event is dropped.
- Elaboration: DATA_WIDTH%8!=0, READ_LATENCY not in {1,2}, or SIZE_MEM > 2**SIZE_ADDR is a fatal error.

Test Plan:
- Defaults. A writes 0xDEADBEEF to address 0x10 with be=0xF; B reads 0x10 two cycles later -> rdvalid_b pulses at acceptance+1 with data_out_b=0xDEADBEEF; coll_cnt=0.
- Byte enables. Preload 0x11223344 at address 5; A writes 0xAABBCCDD with be=0b0101 -> readback 0x11BB33DD.
- Write/write collision, WR_PRIORITY=0. Same cycle: A writes 0xAAAAAAAA with be=0xF; B writes 0xBBBBBBBB with be=0xC, both to address 7 -> ram[7]=0xAAAAAAAA; collision pulses once; coll_cnt=1. Repeat with WR_PRIORITY=1 -> 0xBBBBAAAA.
- Read/write collision plus ce stall, READ_LATENCY=2. ram[3]=1. A reads 3 while B writes 2 to address 3; ce_a drops for 2 cycles after accept -> rdvalid_a is delayed by 2 cycles and returns 1; a subsequent read returns 2.
- SIZE_MEM=200. A writes address 250 and B reads address 250 -> RAM unchanged; data_out_b=0 with rdvalid_b; addr_err=1 and holds until clr_stat; no collision.
- Reset mid-read, READ_LATENCY=2. Assert aresetn=0 one cycle after accept -> outputs go to 0 immediately; no rdvalid after release. Also force coll_cnt to 0xFFFF, then collide again -> coll_cnt stays at 0xFFFF.
